// File: rtl/ad_spi_sampler.sv
// Autonomous 3-wire SPI ADC sampler with an Avalon-MM register file (DATA/STATUS/CONTROL).
// Optional build macro AD_SPI_SAMPLER_AVG_EN publishes the truncated mean of every 4 results.
module ad_spi_sampler #(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 5000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        ad_cs_n,
    output logic        ad_sclk,
    input  logic        ad_sdo
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_QUIET = 3'd4;

    localparam int DIV_W = $clog2(2 * CLK_DIV);
    localparam int PER_W = $clog2(SAMPLE_PERIOD);
    localparam logic [DIV_W-1:0] HALF_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] QUIET_LAST = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [PER_W-1:0] PER_LAST   = PER_W'(SAMPLE_PERIOD - 1);

    logic [2:0]       r_state;
    logic [DIV_W-1:0] r_div_cnt;
    logic [4:0]       r_half_cnt;
    logic [15:0]      r_shift;
    logic             r_sdo_meta;
    logic             r_sdo_sync;
    logic [PER_W-1:0] r_period_cnt;
    logic             r_en;
    logic             r_new;
    logic             r_ovr;
    logic [11:0]      r_data;

    logic        w_ctrl_wr;
    logic        w_status_wr;
    logic        w_data_rd;
    logic        w_period_tick;
    logic        w_trigger;
    logic        w_done;
    logic        w_busy;
    logic [11:0] w_result;
    logic        w_publish;
    logic [11:0] w_pub_data;
    logic        w_unused;

    assign w_ctrl_wr     = write && (address == 2'd2);
    assign w_status_wr   = write && (address == 2'd1);
    assign w_data_rd     = read && (address == 2'd0);
    assign w_period_tick = r_en && (r_period_cnt == '0);
    // Triggers outside IDLE are simply lost; no flag records them.
    assign w_trigger     = (r_state == ST_IDLE) && ((w_ctrl_wr && writedata[1]) || w_period_tick);
    assign w_done        = (r_state == ST_DONE);
    assign w_busy        = (r_state != ST_IDLE);
    assign w_result      = r_shift[11:0];

`ifdef AD_SPI_SAMPLER_AVG_EN
    logic [13:0] r_acc;
    logic [1:0]  r_acc_cnt;
    logic [13:0] w_acc_sum;

    assign w_acc_sum  = r_acc + {2'b00, w_result};
    assign w_publish  = w_done && (r_acc_cnt == 2'd3);
    assign w_pub_data = w_acc_sum[13:2];
    assign w_unused   = &{1'b0, writedata[15:2], r_shift[15:12], w_acc_sum[1:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc     <= '0;
            r_acc_cnt <= '0;
        end else if (w_ctrl_wr) begin
            r_acc     <= '0;
            r_acc_cnt <= '0;
        end else if (w_done) begin
            r_acc     <= (r_acc_cnt == 2'd3) ? 14'd0 : w_acc_sum;
            r_acc_cnt <= r_acc_cnt + 2'd1;
        end
    end
`else
    assign w_publish  = w_done;
    assign w_pub_data = w_result;
    assign w_unused   = &{1'b0, writedata[15:2], r_shift[15:12]};
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sdo_meta <= 1'b0;
            r_sdo_sync <= 1'b0;
        end else begin
            r_sdo_meta <= ad_sdo;
            r_sdo_sync <= r_sdo_meta;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_period_cnt <= PER_LAST;
        end else if (!r_en || (r_period_cnt == '0)) begin
            r_period_cnt <= PER_LAST;
        end else begin
            r_period_cnt <= r_period_cnt - PER_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            ad_cs_n    <= 1'b1;
            ad_sclk    <= 1'b1;
            r_div_cnt  <= '0;
            r_half_cnt <= '0;
            r_shift    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_trigger) begin
                        r_state   <= ST_SETUP;
                        ad_cs_n   <= 1'b0;
                        r_div_cnt <= '0;
                    end
                end
                ST_SETUP: begin
                    if (r_div_cnt == HALF_LAST) begin
                        r_state    <= ST_SHIFT;
                        ad_sclk    <= 1'b0;
                        r_div_cnt  <= '0;
                        r_half_cnt <= '0;
                    end else begin
                        r_div_cnt <= r_div_cnt + DIV_W'(1);
                    end
                end
                ST_SHIFT: begin
                    // 32 half-periods; the last high half completes before CS_n is released.
                    if (r_div_cnt == HALF_LAST) begin
                        r_div_cnt  <= '0;
                        r_half_cnt <= r_half_cnt + 5'd1;
                        if (r_half_cnt == 5'd31) begin
                            r_state <= ST_DONE;
                            ad_cs_n <= 1'b1;
                        end else begin
                            ad_sclk <= ~ad_sclk;
                            if (!ad_sclk) begin
                                r_shift <= {r_shift[14:0], r_sdo_sync};
                            end
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + DIV_W'(1);
                    end
                end
                ST_DONE: begin
                    r_state   <= ST_QUIET;
                    r_div_cnt <= '0;
                end
                ST_QUIET: begin
                    if (r_div_cnt == QUIET_LAST) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_div_cnt <= r_div_cnt + DIV_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    ad_cs_n <= 1'b1;
                    ad_sclk <= 1'b1;
                end
            endcase
        end
    end

    // A DATA read coinciding with a publish leaves NEW set and does not count as overrun.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data <= '0;
            r_new  <= 1'b0;
            r_ovr  <= 1'b0;
            r_en   <= 1'b0;
        end else begin
            if (w_publish) begin
                r_data <= w_pub_data;
            end
            if (w_publish) begin
                r_new <= 1'b1;
            end else if (w_data_rd) begin
                r_new <= 1'b0;
            end
            if (w_publish && r_new && !w_data_rd) begin
                r_ovr <= 1'b1;
            end else if (w_status_wr && writedata[1]) begin
                r_ovr <= 1'b0;
            end
            if (w_ctrl_wr) begin
                r_en <= writedata[0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else if (read) begin
            case (address)
                2'd0:    readdata <= {4'b0000, r_data};
                2'd1:    readdata <= {13'd0, w_busy, r_ovr, r_new};
                2'd2:    readdata <= {15'd0, r_en};
                default: readdata <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_ad_spi_sampler.sv
// Bench for ad_spi_sampler: ADC frame model, register-level reference model, directed + random shots.
// Covers the AD_SPI_SAMPLER_AVG_EN build when that macro is defined.
module tb_ad_spi_sampler;

    localparam int CD = 4;
    localparam int SP = 500;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [15:0] writedata = 16'd0;
    logic [15:0] readdata;
    logic        ad_cs_n;
    logic        ad_sclk;
    logic        ad_sdo = 1'b0;

    always #5 clk = ~clk;

    ad_spi_sampler #(.CLK_DIV(CD), .SAMPLE_PERIOD(SP)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .read(read), .write(write),
        .writedata(writedata), .readdata(readdata), .ad_cs_n(ad_cs_n), .ad_sclk(ad_sclk),
        .ad_sdo(ad_sdo)
    );

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ADC model: each CS_n fall takes the next frame; each SCLK fall presents the next bit, MSB first.
    logic [15:0] frame_q[$];
    logic [15:0] cur_frame = 16'd0;
    int          bit_idx = 15;
    int          cs_falls = 0;

    always @(negedge ad_cs_n) begin
        cur_frame = (frame_q.size() > 0) ? frame_q.pop_front() : 16'd0;
        bit_idx = 15;
        cs_falls++;
    end

    always @(negedge ad_sclk) begin
        if (!ad_cs_n && bit_idx >= 0) begin
            ad_sdo = cur_frame[bit_idx];
            bit_idx--;
        end
    end

    // Register-level reference model
    logic [11:0] m_data = 12'd0;
    bit          m_new = 1'b0;
    bit          m_ovr = 1'b0;
    bit          m_en = 1'b0;
    int          m_acc = 0;
    int          m_cnt = 0;

    function automatic logic [15:0] m_status(input bit busy);
        return {13'd0, busy, m_ovr, m_new};
    endfunction

    task automatic model_done(input logic [15:0] frame, input bit rd);
        bit          pub;
        bit          old_new;
        logic [11:0] val;
        pub = 1'b0;
        val = 12'd0;
`ifdef AD_SPI_SAMPLER_AVG_EN
        m_acc += int'(frame[11:0]);
        m_cnt++;
        if (m_cnt == 4) begin
            pub = 1'b1;
            val = 12'(m_acc / 4);
            m_acc = 0;
            m_cnt = 0;
        end
`else
        pub = 1'b1;
        val = frame[11:0];
`endif
        old_new = m_new;
        if (rd) m_new = 1'b0;
        if (pub) begin
            if (old_new && !rd) m_ovr = 1'b1;
            m_new = 1'b1;
            m_data = val;
        end
    endtask

    task automatic model_reset();
        m_data = 12'd0;
        m_new = 1'b0;
        m_ovr = 1'b0;
        m_en = 1'b0;
        m_acc = 0;
        m_cnt = 0;
    endtask

    task automatic av_write(input logic [1:0] a, input logic [15:0] d);
        address = a;
        writedata = d;
        write = 1'b1;
        @(posedge clk);
        #1 write = 1'b0;
        if (a == 2'd2) begin
            m_en = d[0];
            m_acc = 0;
            m_cnt = 0;
        end
        if (a == 2'd1 && d[1]) m_ovr = 1'b0;
    endtask

    task automatic av_read(input logic [1:0] a, output logic [15:0] d);
        address = a;
        read = 1'b1;
        @(posedge clk);
        #1 read = 1'b0;
        d = readdata;
        if (a == 2'd0) m_new = 1'b0;
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] a, input logic [15:0] exp);
        logic [15:0] d;
        av_read(a, d);
        check(tag, d, exp);
    endtask

    // Single-shot conversion with frame timing checks; optionally reads DATA in the DONE cycle.
    task automatic run_shot(input logic [15:0] frame, input bit rd_done);
        int   n;
        int   falls;
        int   first_fall;
        int   last_fall;
        int   low;
        logic prev;
        logic [11:0] old_data;
        frame_q.push_back(frame);
        av_write(2'd2, {14'd0, 1'b1, m_en});
        check("cs_fall_after_trigger", ad_cs_n, 1'b0);
        n = 0; falls = 0; first_fall = -1; last_fall = -1; low = 0; prev = ad_sclk;
        while (ad_cs_n == 1'b0 && n < 1000) begin
            @(posedge clk);
            #1 n++;
            if (prev && !ad_sclk) begin
                falls++;
                if (first_fall < 0) first_fall = n;
                last_fall = n;
            end
            if (!ad_sclk) low++;
            prev = ad_sclk;
        end
        check("cs_rise_cycle", n, 33 * CD);
        check("sclk_fall_count", falls, 16);
        check("first_sclk_fall", first_fall, CD);
        check("sclk_fall_span", last_fall - first_fall, 30 * CD);
        check("sclk_low_cycles", low, 16 * CD);
        old_data = m_data;
        if (rd_done) begin
            address = 2'd0;
            read = 1'b1;
            @(posedge clk);
            #1 read = 1'b0;
            check("read_in_done_old", readdata, {4'd0, old_data});
            model_done(frame, 1'b1);
        end else begin
            @(posedge clk);
            #1 model_done(frame, 1'b0);
        end
        repeat (7) @(posedge clk);
        #1 chk_reg("status_busy_end", 2'd1, m_status(1'b1));
        chk_reg("status_idle", 2'd1, m_status(1'b0));
    endtask

    task automatic clean_flags();
        logic [15:0] d;
        av_read(2'd0, d);
        av_write(2'd1, 16'h0002);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d;
        logic [15:0] f;
        int f0;
        int n;
        int t1;
        int t2;

        // Reset values
        repeat (3) @(posedge clk);
        #1 check("rst_cs_n", ad_cs_n, 1'b1);
        check("rst_sclk", ad_sclk, 1'b1);
        check("rst_readdata", readdata, 16'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1 chk_reg("rst_data", 2'd0, 16'd0);
        chk_reg("rst_status", 2'd1, 16'd0);
        chk_reg("rst_control", 2'd2, 16'd0);
        av_write(2'd3, 16'hFFFF);
        chk_reg("addr3_reads_0", 2'd3, 16'd0);

        // Single shot with frame 0x0ABC
        run_shot(16'h0ABC, 1'b0);
        chk_reg("shot_status", 2'd1, m_status(1'b0));
        chk_reg("shot_data", 2'd0, {4'd0, m_data});
        chk_reg("shot_status_after_read", 2'd1, m_status(1'b0));
        chk_reg("control_start_reads_0", 2'd2, 16'd0);

        // Randomized shots, random read-back to exercise NEW/OVERRUN
        for (int i = 0; i < 5; i++) begin
            f = 16'($urandom_range(0, 65535));
            run_shot(f, 1'b0);
            if ($urandom_range(0, 1) == 1) chk_reg("rand_data", 2'd0, {4'd0, m_data});
        end
        chk_reg("rand_status", 2'd1, m_status(1'b0));
        av_write(2'd1, 16'h0002);
        chk_reg("ovr_cleared", 2'd1, m_status(1'b0));

        // DATA read landing exactly in the DONE cycle
        clean_flags();
        run_shot(16'h0123, 1'b1);
        chk_reg("rd_done_data", 2'd0, {4'd0, m_data});

        // START while busy is dropped
        clean_flags();
        f0 = cs_falls;
        frame_q.push_back(16'h0555);
        av_write(2'd2, 16'h0002);
        repeat (20) @(posedge clk);
        #1 av_write(2'd2, 16'h0002);
        repeat (400) @(posedge clk);
        #1 check("start_busy_one_frame", cs_falls - f0, 1);
        model_done(16'h0555, 1'b0);
        chk_reg("start_busy_status", 2'd1, m_status(1'b0));
        chk_reg("start_busy_data", 2'd0, {4'd0, m_data});

        // Periodic mode, two conversions with no reads
        clean_flags();
        frame_q.push_back(16'h0100);
        frame_q.push_back(16'h0200);
        f0 = cs_falls;
        av_write(2'd2, 16'h0001);
        n = 0; t1 = -1; t2 = -1;
        while (!((cs_falls - f0) >= 2 && ad_cs_n == 1'b1) && n < 3000) begin
            @(posedge clk);
            #1 n++;
            if (t1 < 0 && (cs_falls - f0) == 1) t1 = n;
            if (t2 < 0 && (cs_falls - f0) == 2) t2 = n;
        end
        check("periodic_first_trigger", t1, SP);
        check("periodic_interval", t2 - t1, SP);
        model_done(16'h0100, 1'b0);
        model_done(16'h0200, 1'b0);
        chk_reg("periodic_control", 2'd2, 16'h0001);
        av_write(2'd2, 16'h0000);
        repeat (12) @(posedge clk);
        #1 chk_reg("periodic_status", 2'd1, m_status(1'b0));
        av_write(2'd1, 16'h0002);
        chk_reg("periodic_ovr_clear", 2'd1, m_status(1'b0));
        chk_reg("periodic_data", 2'd0, {4'd0, m_data});
        chk_reg("periodic_status_end", 2'd1, m_status(1'b0));

`ifdef AD_SPI_SAMPLER_AVG_EN
        // Averaging: four periodic conversions, publish on the fourth
        clean_flags();
        f0 = cs_falls;
        for (int k = 0; k < 4; k++) frame_q.push_back(16'(16'h0010 + k));
        av_write(2'd2, 16'h0001);
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!((cs_falls - f0) >= k + 1 && ad_cs_n == 1'b1) && n < 1000) begin
                @(posedge clk);
                #1 n++;
            end
            model_done(16'(16'h0010 + k), 1'b0);
            repeat (12) @(posedge clk);
            #1 chk_reg("avg_status", 2'd1, m_status(1'b0));
        end
        av_write(2'd2, 16'h0000);
        chk_reg("avg_data", 2'd0, 16'h0011);
`endif

        // Asynchronous reset in the middle of SHIFT
        frame_q.push_back(16'h0FFF);
        av_write(2'd2, 16'h0002);
        repeat (46) @(posedge clk);
        #1 check("pre_reset_sclk_low", ad_sclk, 1'b0);
        #2 reset_n = 1'b0;
        #1 check("async_rst_cs_n", ad_cs_n, 1'b1);
        check("async_rst_sclk", ad_sclk, 1'b1);
        model_reset();
        frame_q.delete();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1 chk_reg("post_rst_status", 2'd1, 16'd0);
        chk_reg("post_rst_data", 2'd0, 16'd0);
        chk_reg("post_rst_control", 2'd2, 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
